// File: rtl/sigma_pkg.sv
// Shared definitions for the sigma datapath collection side.
// Holds default datapath sizes and the collector state encoding.
package sigma_pkg;

  localparam int DFLT_DATA_TYPE = 16;
  localparam int DFLT_NUM_PES   = 4;
  localparam int DFLT_LOG2_PES  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/output_collector_lane_select.sv
// lane_select: priority picker choosing the lowest OUTPUT_BW set bits of mask.
// Ports: mask in; per-lane one-hot/index, cleared mask, lane count, last out.
module lane_select #(
  parameter int NUM_PES   = 4,
  parameter int OUTPUT_BW = 2,
  parameter int LOG2_PES  = 2,
  parameter int CNT_W     = 2
) (
  input  logic [NUM_PES-1:0]           mask,
  output logic [OUTPUT_BW*NUM_PES-1:0] sel_oh,
  output logic [OUTPUT_BW*LOG2_PES-1:0] sel_idx,
  output logic [NUM_PES-1:0]           mask_next,
  output logic [CNT_W-1:0]             count,
  output logic                         last
);

  always_comb begin
    int rank;
    sel_oh    = '0;
    sel_idx   = '0;
    mask_next = mask;
    rank      = 0;
    // rank = number of set bits below p, i.e. the lane p would land on
    for (int p = 0; p < NUM_PES; p++) begin
      if (mask[p]) begin
        for (int l = 0; l < OUTPUT_BW; l++) begin
          if (rank == l) begin
            sel_oh[l*NUM_PES+p] = 1'b1;
            sel_idx[l*LOG2_PES +: LOG2_PES] = LOG2_PES'(p);
            mask_next[p] = 1'b0;
          end
        end
        rank = rank + 1;
      end
    end
    count = CNT_W'((rank < OUTPUT_BW) ? rank : OUTPUT_BW);
    last  = (rank <= OUTPUT_BW);
  end

endmodule

// File: rtl/output_collector.sv
// output_collector: compacts valid PE results onto a narrow output bus.
// Ports: clk/rst, input vector handshake (data+mask), output beat handshake.
module output_collector
  import sigma_pkg::*;
#(
  parameter int DATA_TYPE = DFLT_DATA_TYPE,
  parameter int NUM_PES   = DFLT_NUM_PES,
  parameter int OUTPUT_BW = 2,
  parameter int LOG2_PES  = DFLT_LOG2_PES,
  parameter int CNT_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [NUM_PES*DATA_TYPE-1:0]  i_data_bus,
  input  logic [NUM_PES-1:0]            i_valid_mask,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [OUTPUT_BW*DATA_TYPE-1:0] o_data_bus,
  output logic [OUTPUT_BW*LOG2_PES-1:0] o_pe_id_bus,
  output logic [CNT_W-1:0]              o_count,
  output logic                          o_last
);

  state_t                       state;
  logic [NUM_PES*DATA_TYPE-1:0] data_q;
  logic [NUM_PES-1:0]           mask_q;

  logic [OUTPUT_BW*NUM_PES-1:0]  sel_oh;
  logic [OUTPUT_BW*LOG2_PES-1:0] sel_idx;
  logic [NUM_PES-1:0]            mask_next;
  logic [CNT_W-1:0]              sel_cnt;
  logic                          sel_last;
  logic                          drain;

  lane_select #(
    .NUM_PES  (NUM_PES),
    .OUTPUT_BW(OUTPUT_BW),
    .LOG2_PES (LOG2_PES),
    .CNT_W    (CNT_W)
  ) u_sel (
    .mask     (mask_q),
    .sel_oh   (sel_oh),
    .sel_idx  (sel_idx),
    .mask_next(mask_next),
    .count    (sel_cnt),
    .last     (sel_last)
  );

  assign drain   = (state == DRAIN);
  assign i_ready = (state == IDLE) && !rst;

  assign o_valid     = drain;
  assign o_pe_id_bus = drain ? sel_idx : '0;
  assign o_count     = drain ? sel_cnt : '0;
  assign o_last      = drain && sel_last;

  // AND-OR gather: each lane ORs in the single PE its one-hot selects
  always_comb begin
    o_data_bus = '0;
    for (int l = 0; l < OUTPUT_BW; l++) begin
      for (int p = 0; p < NUM_PES; p++) begin
        o_data_bus[l*DATA_TYPE +: DATA_TYPE] |=
          {DATA_TYPE{drain & sel_oh[l*NUM_PES+p]}} &
          data_q[p*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // empty vectors are consumed without a beat
          if (i_valid && i_ready && (i_valid_mask != '0)) begin
            data_q <= i_data_bus;
            mask_q <= i_valid_mask;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (o_ready) begin
            if (sel_last) begin
              mask_q <= '0;
              state  <= IDLE;
            end else begin
              mask_q <= mask_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
